cache_responder_model: RTL and testbench
========================================

CACHE_RESPONDER_MODEL -- requirements
Module: cache_responder_model

Interface
REQ-001 SHALL have parameter ADDR_W, default 36, request address width.
REQ-002 SHALL have parameter IDX_W, default 10, line index width; array depth is 2**IDX_W lines of 128 bits.
REQ-003 SHALL have parameter LATENCY, default 3, stall cycles per request; legal range 1..15.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port addr  input  ADDR_W  byte address; line index = addr[IDX_W+3:4], other bits ignored.
REQ-007 SHALL have port r  input  1  read request.
REQ-008 SHALL have port w_type  input  2  write type; 00 = none.
REQ-009 SHALL have port flushtype  input  2  flush type; 00 = none.
REQ-010 SHALL have port wr_data  input  128  write line data.
REQ-011 SHALL have port mem_stall_out  output  1  stall to requester; requester holds all inputs while high.
REQ-012 SHALL have port rd_data  output  128  registered read data.
REQ-013 SHALL have port rd_count  output  32  completed reads.
REQ-014 SHALL have port wr_count  output  32  completed writes.

Function
REQ-015 SHALL implement states IDLE, BUSY, SWEEP, DONE.
REQ-016 SHALL treat a request as present when r=1, w_type!=00 or flushtype!=00; priority flush > write > read; a request with both w_type!=00 and r=1 counts as a write only.
REQ-017 SHALL drive mem_stall_out combinationally high in IDLE when a request is present, high throughout BUSY and SWEEP, low in DONE and in IDLE with no request.
REQ-018 SHALL, for a read/write accepted in IDLE at cycle T, hold stall high for cycles T..T+LATENCY-1 (BUSY counts down from LATENCY-1), enter DONE at T+LATENCY with stall low, then return to IDLE.
REQ-019 SHALL load rd_data with the addressed line on the edge entering DONE for reads; rd_data holds otherwise.
REQ-020 SHALL commit writes at the edge leaving DONE; a read of the same line in the next request returns the new data.
REQ-021 SHALL increment rd_count/wr_count by 1 at the edge leaving DONE; counters wrap 0xFFFFFFFF -> 0.
REQ-022 SHALL, for flushtype=11, enter SWEEP and zero one line per cycle from index 0 to 2**IDX_W-1, then enter DONE; total stall = 2**IDX_W + 1 cycles from acceptance.
REQ-023 SHALL treat flushtype 01/10 as no-op acknowledge with read timing (REQ-018), no counter change.
REQ-024 SHALL sample request fields only at acceptance in IDLE; input changes during BUSY/SWEEP/DONE are ignored.
REQ-025 SHALL accept a new request in the IDLE cycle directly following DONE (one idle cycle minimum between requests).

Reset
REQ-026 SHALL, with rst=1 at an edge, set state IDLE, rd_data=0, rd_count=0, wr_count=0, BUSY/SWEEP counters 0.
REQ-027 SHALL abort in-flight requests and sweeps on reset without committing the pending write; array contents are not cleared by reset.
REQ-028 SHALL keep mem_stall_out low during the reset cycle.

Configuration
REQ-029 SHALL support macro CACHE_RSP_HALFLINE_EN.
REQ-030 SHALL, with CACHE_RSP_HALFLINE_EN defined, decode w_type 01 = full line, 10 = bits 63:0 only, 11 = bits 127:64 only, unwritten half preserved.
REQ-031 SHALL, without CACHE_RSP_HALFLINE_EN, write the full 128-bit line for any w_type!=00.

Verification
REQ-032 SHALL test read latency: LATENCY=3, r=1 addr=0x10 after reset -> stall high 3 cycles, 4th cycle stall low, rd_data=0 (post-flush) or preloaded value, rd_count=1.
REQ-033 SHALL test write-then-read: w_type=01 addr=0x20 wr_data=0xA5..A5, then r=1 addr=0x20 -> rd_data=0xA5..A5, wr_count=1, rd_count=1.
REQ-034 SHALL test half-line write with CACHE_RSP_HALFLINE_EN: line=0xFF..FF, w_type=10 wr_data=0 -> read gives 0xFFFFFFFFFFFFFFFF_0000000000000000; same bench without macro -> read gives 0.
REQ-035 SHALL test full flush: IDX_W=4, write 16 lines nonzero, flushtype=11 -> stall 17 cycles, all 16 reads return 0.
REQ-036 SHALL test reset mid-BUSY: w_type=01 addr=0x30 data=0x1, rst at cycle T+1 -> stall low, counters 0, later read of 0x30 returns old value.
REQ-037 SHALL test simultaneous r=1, w_type=01 -> treated as write: wr_count+1, rd_count unchanged.

Source files
------------

// File: rtl/cache_responder_model.sv
// ---------------------------------------------------------------------------
// cache_responder_model
//   Behavioural-timing cache responder. It accepts one read, write or flush
//   request at a time. The requester is stalled for a fixed latency, or for a
//   full-array sweep on a flush-all. The backing array holds 2**IDX_W lines
//   of 128 bits.
//
// Parameters
//   ADDR_W   request address width
//   IDX_W    line index width (array depth 2**IDX_W)
//   LATENCY  stall cycles per read/write/ack request, 1..15
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset (array contents kept)
//   addr           byte address; line index = addr[IDX_W+3:4]
//   r              read request
//   w_type         write type, 00 = none
//   flushtype      flush type, 00 = none, 11 = zero whole array, 01/10 = ack
//   wr_data        write line data
//   mem_stall_out  stall to requester (combinational in IDLE)
//   rd_data        registered read data
//   rd_count       completed reads (wrapping)
//   wr_count       completed writes (wrapping)
//
// Configuration macro
//   CACHE_RSP_HALFLINE_EN  when defined, w_type 10/11 write only the low/high
//                          64-bit half; otherwise any w_type != 00 writes the
//                          full line.
// ---------------------------------------------------------------------------
module cache_responder_model #(
    parameter int ADDR_W  = 36,
    parameter int IDX_W   = 10,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              r,
    input  logic [1:0]        w_type,
    input  logic [1:0]        flushtype,
    input  logic [127:0]      wr_data,
    output logic              mem_stall_out,
    output logic [127:0]      rd_data,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);

    localparam int         DEPTH     = 1 << IDX_W;
    localparam logic [3:0] BUSY_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, SWEEP, DONE} state_t;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_ACK, OP_FLUSH} op_t;

    state_t             state_q, state_d;
    op_t                req_op, op_q, load_op;
    logic               req_present, accept;
    logic [IDX_W-1:0]   req_idx, idx_q, rd_idx, sweep_idx;
    logic [127:0]       wdata_q, cur_line, wr_line;
    logic [3:0]         busy_cnt;
    logic [127:0]       mem [DEPTH];
`ifdef CACHE_RSP_HALFLINE_EN
    logic [1:0]         wtype_q;
`endif

    // Address bits outside the line index are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[ADDR_W-1:IDX_W+4], addr[3:0]};

    assign req_idx     = addr[IDX_W+3:4];
    assign req_present = r | (w_type != 2'b00) | (flushtype != 2'b00);
    assign accept      = (state_q == IDLE) && req_present;

    // Priority: flush (any kind) over write over read.
    always_comb begin
        req_op = OP_RD;
        if (flushtype == 2'b11)      req_op = OP_FLUSH;
        else if (flushtype != 2'b00) req_op = OP_ACK;
        else if (w_type != 2'b00)    req_op = OP_WR;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_present) begin
                    if (req_op == OP_FLUSH) state_d = SWEEP;
                    else if (LATENCY == 1)  state_d = DONE;
                    else                    state_d = BUSY;
                end
            end
            BUSY:    if (busy_cnt <= 4'd1) state_d = DONE;
            SWEEP:   if (sweep_idx == IDX_W'(DEPTH - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mem_stall_out = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:        mem_stall_out = req_present;
                BUSY, SWEEP: mem_stall_out = 1'b1;
                default:     mem_stall_out = 1'b0;
            endcase
        end
    end

    // With LATENCY=1 a read goes straight from IDLE to DONE, so the read
    // index must come from the live inputs rather than the captured copy.
    assign load_op = (state_q == IDLE) ? req_op  : op_q;
    assign rd_idx  = (state_q == IDLE) ? req_idx : idx_q;

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= OP_RD;
            idx_q     <= '0;
            wdata_q   <= '0;
            busy_cnt  <= '0;
            sweep_idx <= '0;
            rd_data   <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
`ifdef CACHE_RSP_HALFLINE_EN
            wtype_q   <= '0;
`endif
        end else begin
            if (accept) begin
                op_q      <= req_op;
                idx_q     <= req_idx;
                wdata_q   <= wr_data;
                busy_cnt  <= BUSY_INIT;
                sweep_idx <= '0;
`ifdef CACHE_RSP_HALFLINE_EN
                wtype_q   <= w_type;
`endif
            end
            if (state_q == BUSY && busy_cnt != 4'd0)
                busy_cnt <= busy_cnt - 4'd1;
            if (state_q == SWEEP)
                sweep_idx <= sweep_idx + 1'b1;
            if (state_d == DONE && state_q != DONE && load_op == OP_RD)
                rd_data <= mem[rd_idx];
            if (state_q == DONE) begin
                if (op_q == OP_RD) rd_count <= rd_count + 32'd1;
                if (op_q == OP_WR) wr_count <= wr_count + 32'd1;
            end
        end
    end

    // ---------------- write merge ----------------
    assign cur_line = mem[idx_q];

    always_comb begin
        wr_line = wdata_q;
`ifdef CACHE_RSP_HALFLINE_EN
        case (wtype_q)
            2'b10:   wr_line = {cur_line[127:64], wdata_q[63:0]};
            2'b11:   wr_line = {wdata_q[127:64], cur_line[63:0]};
            default: wr_line = wdata_q;
        endcase
`else
        wr_line = wdata_q | (cur_line & 128'd0);
`endif
    end

    // Array is not reset; a reset simply suppresses the pending commit/sweep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == SWEEP)
                mem[sweep_idx] <= '0;
            else if (state_q == DONE && op_q == OP_WR)
                mem[idx_q] <= wr_line;
        end
    end

endmodule

// File: tb/tb_cache_responder_model.sv
module tb_cache_responder_model;

    localparam int ADDR_W  = 36;
    localparam int IDX_W   = 4;
    localparam int LATENCY = 3;
    localparam int LINES   = 1 << IDX_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] addr;
    logic              r;
    logic [1:0]        w_type;
    logic [1:0]        flushtype;
    logic [127:0]      wr_data;
    logic              mem_stall_out;
    logic [127:0]      rd_data;
    logic [31:0]       rd_count;
    logic [31:0]       wr_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: plain array plus counters.
    logic [127:0] mdl_mem [LINES];
    logic [127:0] mdl_rd_data;
    logic [31:0]  mdl_rd, mdl_wr;

    cache_responder_model #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst), .addr(addr), .r(r), .w_type(w_type),
        .flushtype(flushtype), .wr_data(wr_data), .mem_stall_out(mem_stall_out),
        .rd_data(rd_data), .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Apply a request to the model; returns expected stall length.
    task automatic model_apply(input logic [ADDR_W-1:0] a, input logic rr, input logic [1:0] wt,
                               input logic [1:0] ft, input logic [127:0] wd, output int exp_stall);
        int idx;
        idx = int'(a[7:4]);
        exp_stall = LATENCY;
        if (ft == 2'b11) begin
            for (int i = 0; i < LINES; i++) mdl_mem[i] = '0;
            exp_stall = LINES + 1;
        end else if (ft != 2'b00) begin
            // acknowledge only
        end else if (wt != 2'b00) begin
`ifdef CACHE_RSP_HALFLINE_EN
            if (wt == 2'b10)      mdl_mem[idx][63:0]   = wd[63:0];
            else if (wt == 2'b11) mdl_mem[idx][127:64] = wd[127:64];
            else                  mdl_mem[idx]         = wd;
`else
            mdl_mem[idx] = wd;
`endif
            mdl_wr = mdl_wr + 1;
        end else if (rr) begin
            mdl_rd_data = mdl_mem[idx];
            mdl_rd = mdl_rd + 1;
        end
    endtask

    // Drive a request starting at posedge+1; returns at the negedge of the
    // first low-stall (DONE) cycle with the number of stalled cycles.
    task automatic do_req(input logic [ADDR_W-1:0] a, input logic rr, input logic [1:0] wt,
                          input logic [1:0] ft, input logic [127:0] wd, input bit scramble,
                          output int stalls);
        addr = a; r = rr; w_type = wt; flushtype = ft; wr_data = wd;
        stalls = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!mem_stall_out) break;
            stalls++;
            @(posedge clk); #1;
            if (scramble && stalls == 1) begin
                addr = {4'($urandom), 32'($urandom)};
                r = 1'($urandom); w_type = 2'($urandom); flushtype = 2'($urandom_range(0, 2));
                wr_data = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    endtask

    // Leave the DONE cycle and idle the inputs.
    task automatic finish_req();
        @(posedge clk); #1;
        addr = '0; r = 1'b0; w_type = 2'b00; flushtype = 2'b00; wr_data = '0;
    endtask

    task automatic test_reset();
        r = 1'b1; addr = 36'h10;
        @(negedge clk);
        vectors++;
        if (mem_stall_out !== 1'b0) begin
            miscompares++; $display("FAIL reset_stall: got %b want 0", mem_stall_out);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (rd_data !== '0 || rd_count !== 32'd0 || wr_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_regs: rd_data=%h rd_count=%0d wr_count=%0d want 0/0/0", rd_data, rd_count, wr_count);
        end
        @(posedge clk); #1;
        rst = 1'b0; r = 1'b0; addr = '0;
        @(negedge clk);
        vectors++;
        if (mem_stall_out !== 1'b0) begin
            miscompares++; $display("FAIL idle_stall: got %b want 0", mem_stall_out);
        end
        @(posedge clk); #1;
        mdl_rd = 0; mdl_wr = 0; mdl_rd_data = '0;
    endtask

    task automatic test_flush();
        int st, es;
        for (int i = 0; i < LINES; i++) begin
            logic [127:0] d;
            d = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
            model_apply(ADDR_W'(i * 16), 1'b0, 2'b01, 2'b00, d, es);
            do_req(ADDR_W'(i * 16), 1'b0, 2'b01, 2'b00, d, 1'b0, st);
            finish_req();
        end
        model_apply('0, 1'b0, 2'b00, 2'b11, '0, es);
        do_req('0, 1'b0, 2'b00, 2'b11, '0, 1'b0, st);
        vectors++;
        if (st !== LINES + 1 || es !== LINES + 1) begin
            miscompares++; $display("FAIL flush_stall: got %0d want %0d", st, LINES + 1);
        end
        finish_req();
        for (int i = 0; i < LINES; i++) begin
            model_apply(ADDR_W'(i * 16), 1'b1, 2'b00, 2'b00, '0, es);
            do_req(ADDR_W'(i * 16), 1'b1, 2'b00, 2'b00, '0, 1'b0, st);
            vectors++;
            if (rd_data !== 128'd0) begin
                miscompares++; $display("FAIL flush_read[%0d]: got %h want 0", i, rd_data);
            end
            finish_req();
        end
        vectors++;
        if (wr_count !== mdl_wr || rd_count !== mdl_rd) begin
            miscompares++;
            $display("FAIL flush_counts: rd=%0d wr=%0d want %0d/%0d", rd_count, wr_count, mdl_rd, mdl_wr);
        end
    endtask

    task automatic test_read_latency();
        int st, es;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        mdl_rd = 0; mdl_wr = 0; mdl_rd_data = '0;
        model_apply(36'h10, 1'b1, 2'b00, 2'b00, '0, es);
        do_req(36'h10, 1'b1, 2'b00, 2'b00, '0, 1'b0, st);
        vectors++;
        if (st !== 3) begin
            miscompares++; $display("FAIL read_latency: got %0d want 3", st);
        end
        vectors++;
        if (rd_data !== 128'd0) begin
            miscompares++; $display("FAIL read_data: got %h want 0", rd_data);
        end
        finish_req();
        vectors++;
        if (rd_count !== 32'd1) begin
            miscompares++; $display("FAIL read_count: got %0d want 1", rd_count);
        end
    endtask

    task automatic test_write_read();
        int st, es;
        logic [127:0] pat;
        pat = {16{8'hA5}};
        model_apply(36'h20, 1'b0, 2'b01, 2'b00, pat, es);
        do_req(36'h20, 1'b0, 2'b01, 2'b00, pat, 1'b0, st);
        finish_req();
        model_apply(36'h20, 1'b1, 2'b00, 2'b00, '0, es);
        do_req(36'h20, 1'b1, 2'b00, 2'b00, '0, 1'b0, st);
        vectors++;
        if (rd_data !== pat) begin
            miscompares++; $display("FAIL write_read: got %h want %h", rd_data, pat);
        end
        finish_req();
        vectors++;
        if (wr_count !== 32'd1 || rd_count !== 32'd2) begin
            miscompares++; $display("FAIL write_read_counts: rd=%0d wr=%0d want 2/1", rd_count, wr_count);
        end
    endtask

    task automatic test_halfline();
        int st, es;
        logic [127:0] want;
        model_apply(36'h40, 1'b0, 2'b01, 2'b00, '1, es);
        do_req(36'h40, 1'b0, 2'b01, 2'b00, '1, 1'b0, st); finish_req();
        model_apply(36'h40, 1'b0, 2'b10, 2'b00, '0, es);
        do_req(36'h40, 1'b0, 2'b10, 2'b00, '0, 1'b0, st); finish_req();
        model_apply(36'h40, 1'b1, 2'b00, 2'b00, '0, es);
        do_req(36'h40, 1'b1, 2'b00, 2'b00, '0, 1'b0, st);
`ifdef CACHE_RSP_HALFLINE_EN
        want = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
`else
        want = 128'd0;
`endif
        vectors++;
        if (rd_data !== want) begin
            miscompares++; $display("FAIL halfline_lo: got %h want %h", rd_data, want);
        end
        finish_req();
        model_apply(36'h40, 1'b0, 2'b11, 2'b00, {64'h1234_5678_9ABC_DEF0, 64'h5555}, es);
        do_req(36'h40, 1'b0, 2'b11, 2'b00, {64'h1234_5678_9ABC_DEF0, 64'h5555}, 1'b0, st); finish_req();
        model_apply(36'h40, 1'b1, 2'b00, 2'b00, '0, es);
        do_req(36'h40, 1'b1, 2'b00, 2'b00, '0, 1'b0, st);
        vectors++;
        if (rd_data !== mdl_rd_data) begin
            miscompares++; $display("FAIL halfline_hi: got %h want %h", rd_data, mdl_rd_data);
        end
        finish_req();
    endtask

    task automatic test_reset_mid_busy();
        int st, es;
        logic [127:0] old;
        old = mdl_mem[3];
        addr = 36'h30; w_type = 2'b01; wr_data = 128'h1;
        @(posedge clk); #1;                // now in cycle T+1
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (mem_stall_out !== 1'b0) begin
            miscompares++; $display("FAIL rst_busy_stall: got %b want 0", mem_stall_out);
        end
        @(posedge clk); #1;
        rst = 1'b0; addr = '0; w_type = 2'b00; wr_data = '0;
        mdl_rd = 0; mdl_wr = 0; mdl_rd_data = '0;
        @(negedge clk);
        vectors++;
        if (mem_stall_out !== 1'b0 || rd_count !== 32'd0 || wr_count !== 32'd0 || rd_data !== '0) begin
            miscompares++;
            $display("FAIL rst_busy_state: stall=%b rd=%0d wr=%0d data=%h want 0", mem_stall_out, rd_count, wr_count, rd_data);
        end
        @(posedge clk); #1;
        model_apply(36'h30, 1'b1, 2'b00, 2'b00, '0, es);
        do_req(36'h30, 1'b1, 2'b00, 2'b00, '0, 1'b0, st);
        vectors++;
        if (rd_data !== old) begin
            miscompares++; $display("FAIL rst_busy_old: got %h want %h", rd_data, old);
        end
        finish_req();
    endtask

    task automatic test_simultaneous();
        int st, es;
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        model_apply(36'h50, 1'b1, 2'b01, 2'b00, d, es);
        do_req(36'h50, 1'b1, 2'b01, 2'b00, d, 1'b0, st);
        finish_req();
        vectors++;
        if (wr_count !== mdl_wr || rd_count !== mdl_rd) begin
            miscompares++;
            $display("FAIL simul_counts: rd=%0d wr=%0d want %0d/%0d", rd_count, wr_count, mdl_rd, mdl_wr);
        end
    endtask

    task automatic test_random();
        int st, es, k;
        logic [ADDR_W-1:0] a;
        logic rr; logic [1:0] wt, ft; logic [127:0] d;
        for (int n = 0; n < 60; n++) begin
            a  = {4'($urandom), 24'($urandom), 4'($urandom_range(0, LINES - 1)), 4'($urandom)};
            d  = {$urandom, $urandom, $urandom, $urandom};
            k  = $urandom_range(0, 19);
            rr = 1'b0; wt = 2'b00; ft = 2'b00;
            if (k < 8)       rr = 1'b1;
            else if (k < 14) wt = 2'($urandom_range(1, 3));
            else if (k < 16) begin rr = 1'b1; wt = 2'($urandom_range(1, 3)); end
            else if (k < 19) begin ft = 2'($urandom_range(1, 2)); rr = 1'($urandom); wt = 2'($urandom); end
            else             ft = 2'b11;
            model_apply(a, rr, wt, ft, d, es);
            do_req(a, rr, wt, ft, d, 1'($urandom), st);
            vectors++;
            if (st !== es) begin
                miscompares++; $display("FAIL rand_stall[%0d]: got %0d want %0d", n, st, es);
            end
            vectors++;
            if (rd_data !== mdl_rd_data) begin
                miscompares++; $display("FAIL rand_data[%0d]: got %h want %h", n, rd_data, mdl_rd_data);
            end
            finish_req();
            vectors++;
            if (rd_count !== mdl_rd || wr_count !== mdl_wr) begin
                miscompares++;
                $display("FAIL rand_counts[%0d]: rd=%0d wr=%0d want %0d/%0d", n, rd_count, wr_count, mdl_rd, mdl_wr);
            end
        end
    endtask

    initial begin
        rst = 1'b1; addr = '0; r = 1'b0; w_type = 2'b00; flushtype = 2'b00; wr_data = '0;
        for (int i = 0; i < LINES; i++) mdl_mem[i] = '0;
        mdl_rd = 0; mdl_wr = 0; mdl_rd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_flush();
        test_read_latency();
        test_write_read();
        test_halfline();
        test_reset_mid_busy();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
